regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares one integer register-file write port between NumReq writeback sources
//   (e.g. ALU, LSU, mul/div, vector scalar-result path).
//   - Round-robin grant, at most one write per cycle.
//   - Registers the winning write, then drives the regfile write port.
//   - Suppresses writes to x0.
//   - Publishes a one-hot "write in flight" view for hazard logic.
// PARAMETERS
//   XLEN      32                 data width of a register
//   RegNum    32                 number of architectural registers
//   RegWidth  $clog2(RegNum)     register address width
//   NumReq    4                  number of writeback requesters (>=1)
// PORTS
//   clk_i          in   1                 clock
//   rst_ni         in   1                 reset, asynchronous, active-low
//   req_valid_i    in   NumReq            requester i has a write pending
//   req_ready_o    out  NumReq            write i accepted this cycle (one-hot or zero)
//   req_addr_i     in   NumReq*RegWidth   destination register per requester
//   req_data_i     in   NumReq*XLEN       write data per requester
//   stall_i        in   1                 block all grants this cycle
//   reg_wen_o      out  1                 regfile write enable (registered)
//   reg_waddr_o    out  RegWidth          regfile write address (registered)
//   reg_wdata_o    out  XLEN              regfile write data (registered)
//   inflight_o     out  RegNum            one-hot of reg_waddr_o when reg_wen_o=1, else 0
//   grant_idx_o    out  $clog2(NumReq)    index of last granted requester (registered)
// BEHAVIOUR
// Reset
//   - rst_ni low: reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, grant_idx_o=0, rr pointer ptr_q=0.
//   - req_ready_o=0 while in reset.
//   - A write held in the output stage when reset asserts is discarded; it never reaches the regfile.
// Arbitration (combinational, same cycle)
//   - Candidate set: requesters with req_valid_i=1.
//   - Search starts at index ptr_q and rises, wrapping at NumReq-1 -> 0.
//   - First valid index found wins.
//   - stall_i=1 or no valid request: no grant, req_ready_o=0.
//   - Winner g: req_ready_o[g]=1; all other ready bits 0. Transfer completes when valid&ready.
//   - Ready depends on valid. Requesters must not derive valid from ready.
//   - Requesters hold valid/addr/data stable until accepted.
// Pointer update
//   - On grant: ptr_q <= (g+1) mod NumReq.
//   - No grant: ptr_q holds.
//   - Result: a continuously-valid requester waits at most NumReq-1 grants.
// Output stage (latency 1)
//   - Cycle after a grant: reg_wen_o=1, reg_waddr_o=req_addr_i[g], reg_wdata_o=req_data_i[g], grant_idx_o=g.
//   - x0: if req_addr_i[g]==0 the grant still occurs (ready=1, ptr advances) but reg_wen_o=0 next cycle.
//   - No grant: reg_wen_o=0 next cycle. addr/data/grant_idx_o hold their previous values.
//   - The regfile accepts every write, so the output stage never back-pressures.
//   - Back-to-back grants each cycle sustain 1 write/cycle.
// Boundaries
//   - NumReq=1: pointer stays 0; behaviour is a registered pass-through with x0 suppression.
//   - Same destination from two requesters in one cycle: only the winner is written.
//     The loser retries and writes later, so the last write wins in grant order.
//   - Data readers see the new value 2 cycles after the handshake (output register + regfile register).
//     Hazard logic uses inflight_o to cover the gap.
// STRUCTURE
//   - Shared package regfile_pkg: XLEN, RegNum, RegWidth defaults; typedef wb_req_t {addr, data}.
//   - Sub-module rr_arbiter #(N): req vector + ptr in, one-hot grant + index out, purely combinational.
//     regfile_wb_arbiter owns ptr_q and the output-stage flops.
// TESTING
//   1. Reset: hold rst_ni=0 with all valid=1
//      -> ready=0, reg_wen_o=0, inflight_o=0; after release, first grant goes to req0.
//   2. Round-robin: NumReq=4, all valid continuously
//      -> grants 0,1,2,3,0,...; reg_wen_o=1 every cycle; each waddr/wdata matches the source one cycle later.
//   3. x0: req1 valid, addr=0, data=32'hDEADBEEF
//      -> ready[1]=1 that cycle; next cycle reg_wen_o=0, inflight_o=0; ptr_q=2.
//   4. Stall: all valid, stall_i=1 for 3 cycles
//      -> ready=0 and reg_wen_o=0 for those cycles; ptr_q unchanged; granting resumes at the same index.
//   5. Conflict: req0 and req2 both write x5 (0x11, 0x22), ptr_q=2
//      -> x5=0x22 first, then 0x11 next cycle; inflight_o=32'h20 on both cycles.
//   6. Mid-flight reset: grant req3 to x7, assert rst_ni on the next edge
//      -> reg_wen_o drops asynchronously; x7 is never written.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request payload type.
package regfile_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RegNum   = 32;
  localparam int unsigned RegWidth = $clog2(RegNum);

  typedef struct packed {
    logic [RegWidth-1:0] addr;
    logic [XLEN-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_c_o,
  output logic [IdxW-1:0] idx_c_o,
  output logic            any_c_o
);

  logic [IdxW-1:0] j;

  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    any_c_o = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IdxW'((32'(ptr_i) + k) % N);
      if (!any_c_o && req_i[j]) begin
        any_c_o    = 1'b1;
        gnt_c_o[j] = 1'b1;
        idx_c_o    = j;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of NumReq writeback sources onto one registered
// regfile write port, with x0 suppression and a one-hot in-flight view.
module regfile_wb_arbiter #(
  parameter  int unsigned XLEN     = regfile_pkg::XLEN,
  parameter  int unsigned RegNum   = regfile_pkg::RegNum,
  parameter  int unsigned RegWidth = $clog2(RegNum),
  parameter  int unsigned NumReq   = 4,
  localparam int unsigned IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq*RegWidth-1:0] req_addr_i,
  input  logic [NumReq*XLEN-1:0]   req_data_i,
  input  logic                     stall_i,
  output logic                     reg_wen_o,
  output logic [RegWidth-1:0]      reg_waddr_o,
  output logic [XLEN-1:0]          reg_wdata_o,
  output logic [RegNum-1:0]        inflight_o,
  output logic [IdxW-1:0]          grant_idx_o
);

  logic [NumReq-1:0]   req_eff;
  logic [NumReq-1:0]   gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_any;
  logic [RegWidth-1:0] addr_arr [NumReq];
  logic [XLEN-1:0]     data_arr [NumReq];

  logic [IdxW-1:0]     ptr_q,      ptr_d;
  logic                wen_q,      wen_d;
  logic [RegWidth-1:0] waddr_q,    waddr_d;
  logic [XLEN-1:0]     wdata_q,    wdata_d;
  logic [IdxW-1:0]     gidx_q,     gidx_d;
  logic [RegNum-1:0]   inflight_q, inflight_d;

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      addr_arr[k] = req_addr_i[k*RegWidth +: RegWidth];
      data_arr[k] = req_data_i[k*XLEN +: XLEN];
    end
  end

  assign req_eff = stall_i ? '0 : req_valid_i;

  rr_arbiter #(.N(NumReq)) u_rr (
    .req_i   (req_eff),
    .ptr_i   (ptr_q),
    .gnt_c_o (gnt),
    .idx_c_o (gnt_idx),
    .any_c_o (gnt_any)
  );

  // Ready is masked while reset is held so nothing is accepted then dropped.
  assign req_ready_o = rst_ni ? gnt : '0;

  always_comb begin
    ptr_d      = ptr_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    gidx_d     = gidx_q;
    inflight_d = '0;
    if (gnt_any) begin
      ptr_d   = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
      wen_d   = (addr_arr[gnt_idx] != '0);
      waddr_d = addr_arr[gnt_idx];
      wdata_d = data_arr[gnt_idx];
      gidx_d  = gnt_idx;
    end
    if (wen_d) begin
      inflight_d = RegNum'(1) << waddr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      gidx_q     <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      gidx_q     <= gidx_d;
      inflight_q <= inflight_d;
    end
  end

  assign reg_wen_o   = wen_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;
  assign grant_idx_o = gidx_q;
  assign inflight_o  = inflight_q;

endmodule
